kalkulator_sekwencer: RTL and testbench

Clocked sequencer for the board calculator. It filters the three operation keys and latches the 5-bit operands from the switches. It runs add, subtract (with sign) or a multi-cycle shift-add multiply, then converts the binary result to four BCD digits with a sequential double-dabble. It sits between the raw board inputs (KEY, SW) and the 7-segment digit decoders, and holds the last result stable until the next accepted command.

---
 rtl/kalkulator_sekwencer.sv | 155 +++++++++++++++
 tb/tb_kalkulator_sekwencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/kalkulator_sekwencer.sv
// Board calculator sequencer: debounced key commands, add/sub/shift-add multiply,
// then sequential double-dabble into four BCD digits held until the next result.
module kalkulator_sekwencer #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic       CLOCK_50,
   input  logic       RST,
   input  logic [2:0] KEY,
   input  logic [9:0] SW,
   output logic [3:0] cyfra0,
   output logic [3:0] cyfra1,
   output logic [3:0] cyfra2,
   output logic [3:0] cyfra3,
   output logic       ujemny,
   output logic       zajety,
   output logic       gotowe
);

   localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StMul, StConv, StDone} state_e;

   logic [2:0]      sync1_q, sync2_q, pressed_q;
   logic [CntW-1:0] db_cnt_q [3];
   logic [2:0]      differ, flip, press_ev;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         differ[k]   = (~sync2_q[k]) != pressed_q[k];
         flip[k]     = differ[k] && (db_cnt_q[k] == CntW'(DB_CYCLES - 1));
         press_ev[k] = flip[k] && !pressed_q[k];
      end
   end

   // Keys are active-low, so the synchronizer idles at 1 (released).
   always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
         sync1_q   <= 3'b111;
         sync2_q   <= 3'b111;
         pressed_q <= 3'b000;
         for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
      end else begin
         sync1_q <= KEY;
         sync2_q <= sync1_q;
         for (int k = 0; k < 3; k++) begin
            if (!differ[k]) begin
               db_cnt_q[k] <= '0;
            end else if (flip[k]) begin
               db_cnt_q[k]  <= '0;
               pressed_q[k] <= ~pressed_q[k];
            end else begin
               db_cnt_q[k] <= db_cnt_q[k] + CntW'(1);
            end
         end
      end
   end

   state_e      state_q;
   logic [9:0]  mcand_q, acc_q, bin_q;
   logic [4:0]  mplier_q;
   logic [15:0] bcd_q, cyfra_q;
   logic [3:0]  step_q;
   logic        neg_q, ujemny_q, zajety_q, gotowe_q;

   logic [5:0]  sum6, diff6, mag6;
   logic [9:0]  acc_nxt;
   logic [15:0] bcd_adj;

   always_comb begin
      sum6    = {1'b0, SW[4:0]} + {1'b0, SW[9:5]};
      diff6   = {1'b0, SW[4:0]} - {1'b0, SW[9:5]};
      mag6    = diff6[5] ? 6'(6'd0 - diff6) : diff6;
      acc_nxt = acc_q + (mplier_q[0] ? mcand_q : 10'd0);
      for (int i = 0; i < 4; i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                       : bcd_q[4*i +: 4];
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         bin_q    <= '0;
         bcd_q    <= '0;
         step_q   <= '0;
         neg_q    <= 1'b0;
         cyfra_q  <= '0;
         ujemny_q <= 1'b0;
         zajety_q <= 1'b0;
         gotowe_q <= 1'b0;
      end else begin
         gotowe_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // KEY0 > KEY1 > KEY2; losing same-cycle events are dropped.
               if (|press_ev) begin
                  zajety_q <= 1'b1;
                  step_q   <= '0;
                  bcd_q    <= '0;
                  neg_q    <= 1'b0;
                  if (press_ev[0]) begin
                     bin_q   <= {4'd0, sum6};
                     state_q <= StConv;
                  end else if (press_ev[1]) begin
                     bin_q   <= {4'd0, mag6};
                     neg_q   <= diff6[5];
                     state_q <= StConv;
                  end else begin
                     mcand_q  <= {5'd0, SW[4:0]};
                     mplier_q <= SW[9:5];
                     acc_q    <= '0;
                     state_q  <= StMul;
                  end
               end
            end
            StMul: begin
               acc_q    <= acc_nxt;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               step_q   <= step_q + 4'd1;
               if (step_q == 4'd4) begin
                  bin_q   <= acc_nxt;
                  step_q  <= '0;
                  state_q <= StConv;
               end
            end
            StConv: begin
               {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
               step_q         <= step_q + 4'd1;
               if (step_q == 4'd9) state_q <= StDone;
            end
            StDone: begin
               cyfra_q  <= bcd_q;
               ujemny_q <= neg_q;
               gotowe_q <= 1'b1;
               zajety_q <= 1'b0;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cyfra0 = cyfra_q[3:0];
   assign cyfra1 = cyfra_q[7:4];
   assign cyfra2 = cyfra_q[11:8];
   assign cyfra3 = cyfra_q[15:12];
   assign ujemny = ujemny_q;
   assign zajety = zajety_q;
   assign gotowe = gotowe_q;

endmodule

// File: tb/tb_kalkulator_sekwencer.sv
// Directed bench for kalkulator_sekwencer: latency, digits, sign, contention, glitch, reset.
module tb_kalkulator_sekwencer;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] key = 3'b111;
   logic [9:0] sw  = '0;
   logic [3:0] c0, c1, c2, c3;
   logic       ujemny, zajety, gotowe;

   int checks   = 0;
   int failures = 0;

   kalkulator_sekwencer #(.DB_CYCLES(DB)) dut (
      .CLOCK_50(clk),
      .RST     (rst),
      .KEY     (key),
      .SW      (sw),
      .cyfra0  (c0),
      .cyfra1  (c1),
      .cyfra2  (c2),
      .cyfra3  (c3),
      .ujemny  (ujemny),
      .zajety  (zajety),
      .gotowe  (gotowe)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] digits();
      return {c3, c2, c1, c0};
   endfunction

   // Press keys, measure zajety->gotowe distance, check result, release and check hold.
   task automatic run_cmd(input string tag, input logic [2:0] keys, input logic [9:0] swv,
                          input int lat, input logic [15:0] dig, input logic neg);
      int n;
      int pulses;
      logic dropped;
      sw  = swv;
      key = ~keys;
      n   = 0;
      while (!zajety && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_busy"}, {15'd0, zajety}, 16'd1);
      sw      = ~swv;
      n       = 0;
      dropped = 1'b0;
      while (!gotowe && n < 40) begin
         if (!zajety) dropped = 1'b1;
         tick();
         n++;
      end
      chk({tag, "_lat"}, 16'(n), 16'(lat));
      chk({tag, "_busyheld"}, {15'd0, dropped}, 16'd0);
      chk({tag, "_idle_at_gotowe"}, {15'd0, zajety}, 16'd0);
      chk({tag, "_digits"}, digits(), dig);
      chk({tag, "_neg"}, {15'd0, ujemny}, {15'd0, neg});
      key    = 3'b111;
      pulses = 0;
      for (int i = 0; i < DB + 8; i++) begin
         tick();
         if (gotowe) pulses++;
      end
      chk({tag, "_single_pulse"}, 16'(pulses), 16'd0);
      chk({tag, "_hold"}, digits(), dig);
   endtask

   initial begin
      int n;
      int pulses;
      int busy_cnt;

      // Power-on reset and long idle.
      repeat (3) tick();
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (gotowe) pulses++;
      end
      chk("rst_digits", digits(), 16'h0000);
      chk("rst_flags", {13'd0, ujemny, zajety, gotowe}, 16'd0);
      chk("rst_no_gotowe", 16'(pulses), 16'd0);

      run_cmd("add_12_7",  3'b001, 10'h0EC, 11, 16'h0019, 1'b0);
      run_cmd("add_31_31", 3'b001, 10'h3FF, 11, 16'h0062, 1'b0);
      run_cmd("sub_3_10",  3'b010, 10'h143, 11, 16'h0007, 1'b1);
      run_cmd("sub_31_31", 3'b010, 10'h3FF, 11, 16'h0000, 1'b0);
      run_cmd("sub_20_5",  3'b010, 10'h0B4, 11, 16'h0015, 1'b0);
      run_cmd("mul_31_31", 3'b100, 10'h3FF, 16, 16'h0961, 1'b0);
      run_cmd("mul_12_7",  3'b100, 10'h0EC, 16, 16'h0084, 1'b0);

      // KEY0 and KEY2 together: add wins.
      run_cmd("add_vs_mul", 3'b101, 10'h0EC, 11, 16'h0019, 1'b0);

      // KEY1 pressed while busy must be discarded.
      sw  = 10'h0EC;
      key = 3'b110;
      n   = 0;
      while (!zajety && n < 40) begin
         tick();
         n++;
      end
      chk("busy_key_start", {15'd0, zajety}, 16'd1);
      key    = 3'b101;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 12) key = 3'b111;
         tick();
         if (gotowe) pulses++;
      end
      chk("busy_key_pulses", 16'(pulses), 16'd1);
      chk("busy_key_digits", digits(), 16'h0019);
      chk("busy_key_neg", {15'd0, ujemny}, 16'd0);

      // Glitch one cycle shorter than the filter window.
      key = 3'b110;
      repeat (DB - 1) tick();
      key      = 3'b111;
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (zajety) busy_cnt++;
      end
      chk("glitch_no_cmd", 16'(busy_cnt), 16'd0);
      run_cmd("after_glitch", 3'b001, 10'h0EC, 11, 16'h0019, 1'b0);

      // Asynchronous reset mid-cycle with a negative result on display.
      run_cmd("sub_pre_rst", 3'b010, 10'h143, 11, 16'h0007, 1'b1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_digits", digits(), 16'h0000);
      chk("async_rst_flags", {13'd0, ujemny, zajety, gotowe}, 16'd0);
      tick();
      rst = 1'b0;

      // Reset during multiply abandons it.
      run_cmd("add_pre_midop", 3'b001, 10'h3FF, 11, 16'h0062, 1'b0);
      sw  = 10'h3FF;
      key = 3'b011;
      n   = 0;
      while (!zajety && n < 40) begin
         tick();
         n++;
      end
      chk("midop_busy", {15'd0, zajety}, 16'd1);
      key = 3'b111;
      repeat (7) tick();
      #2 rst = 1'b1;
      #1;
      chk("midop_rst_digits", digits(), 16'h0000);
      chk("midop_rst_busy", {15'd0, zajety}, 16'd0);
      tick();
      tick();
      rst      = 1'b0;
      pulses   = 0;
      busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (gotowe) pulses++;
         if (zajety) busy_cnt++;
      end
      chk("midop_abandon_pulse", 16'(pulses), 16'd0);
      chk("midop_abandon_busy", 16'(busy_cnt), 16'd0);
      run_cmd("add_after_midop", 3'b001, 10'h0EC, 11, 16'h0019, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
